// File: rtl/ucie_mb_clk_pkg.sv
// Shared definitions for the MB forwarded-clock training logic: FSM states,
// default field widths and the legacy fixed-pattern constants.
package ucie_mb_clk_pkg;

  localparam int unsigned DEF_NUM_CH = 3;
  localparam int unsigned DEF_LEN_W  = 5;
  localparam int unsigned DEF_ITER_W = 7;

  localparam int unsigned LEGACY_ON_LEN   = 16;
  localparam int unsigned LEGACY_OFF_LEN  = 8;
  localparam int unsigned LEGACY_ITER_NUM = 127;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_ON   = 3'd2,
    ST_OFF  = 3'd3,
    ST_DONE = 3'd4
  } train_state_e;

  function automatic logic is_busy_state(input train_state_e s);
    return (s == ST_LOAD) || (s == ST_ON) || (s == ST_OFF);
  endfunction

endpackage

// File: rtl/clk_train_pattern_gen_if.sv
// Control/status bundle between the training sequencer and the pattern generator.
interface clk_train_pattern_gen_if
  import ucie_mb_clk_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned ITER_W = DEF_ITER_W
) ();

  // Request/complete handshake: a rising edge on i_start launches one run; the
  // run's configuration is latched once, o_done then holds until i_start drops,
  // and i_start must be seen low before a new rising edge can start another run.
  logic              i_start;
  logic              i_abort;
  logic [LEN_W-1:0]  i_on_len;
  logic [LEN_W-1:0]  i_off_len;
  logic [ITER_W-1:0] i_iter_num;
  logic [NUM_CH-1:0] i_ch_mask;
  logic              i_park;

  logic [NUM_CH-1:0] o_clk_en;
  logic              o_busy;
  logic              o_done;
  logic [ITER_W-1:0] o_iter_cnt;
  train_state_e      o_state;

  modport master (
    output i_start, i_abort, i_on_len, i_off_len, i_iter_num, i_ch_mask, i_park,
    input  o_clk_en, o_busy, o_done, o_iter_cnt, o_state
  );

  modport slave (
    input  i_start, i_abort, i_on_len, i_off_len, i_iter_num, i_ch_mask, i_park,
    output o_clk_en, o_busy, o_done, o_iter_cnt, o_state
  );

endinterface

// File: rtl/clk_train_phase_cnt.sv
// Down-counter timing one ON or OFF phase; loaded with length-1 on phase entry,
// the zero flag marks the final cycle of the phase.
module clk_train_phase_cnt #(
  parameter int unsigned LEN_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [LEN_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/clk_train_pattern_gen.sv
// Forwarded-clock training pattern generator: drives per-channel gate enables
// with ON_LEN enabled / OFF_LEN gated cycles, repeated ITER_NUM times per run.
module clk_train_pattern_gen
  import ucie_mb_clk_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned ITER_W = DEF_ITER_W
) (
  input logic                    i_clk,
  input logic                    i_rst,
  clk_train_pattern_gen_if.slave bus
);

  train_state_e      state_q;
  logic              start_q;
  logic              rise;

  logic [LEN_W-1:0]  on_sh_q;
  logic [LEN_W-1:0]  off_sh_q;
  logic [ITER_W-1:0] iter_sh_q;
  logic [NUM_CH-1:0] mask_sh_q;

  logic [ITER_W-1:0] iter_cnt_q;
  logic [NUM_CH-1:0] clk_en_q;
  logic              busy_q;
  logic              done_q;

  logic [LEN_W-1:0]  on_len_eff;
  logic [ITER_W:0]   iter_inc;
  logic              iter_last;
  logic [ITER_W-1:0] iter_sat;
  logic [NUM_CH-1:0] idle_en;

  logic              ph_load;
  logic              ph_dec;
  logic [LEN_W-1:0]  ph_load_val;
  logic              ph_zero;

  assign rise       = bus.i_start & ~start_q;
  assign on_len_eff = (bus.i_on_len == '0) ? LEN_W'(1) : bus.i_on_len;
  assign iter_inc   = {1'b0, iter_cnt_q} + 1'b1;
  assign iter_last  = (iter_inc == {1'b0, iter_sh_q});
  assign iter_sat   = (&iter_cnt_q) ? iter_cnt_q : iter_inc[ITER_W-1:0];
  assign idle_en    = {NUM_CH{~bus.i_park}};

  // Phase counter is reloaded on every phase entry so ON and OFF share it.
  always_comb begin
    ph_load     = 1'b0;
    ph_dec      = 1'b0;
    ph_load_val = '0;
    if (!bus.i_abort) begin
      case (state_q)
        ST_LOAD: begin
          ph_load     = 1'b1;
          ph_load_val = on_len_eff - 1'b1;
        end
        ST_ON: begin
          if (!ph_zero) begin
            ph_dec = 1'b1;
          end else if (off_sh_q != '0) begin
            ph_load     = 1'b1;
            ph_load_val = off_sh_q - 1'b1;
          end else if (!iter_last) begin
            ph_load     = 1'b1;
            ph_load_val = on_sh_q - 1'b1;
          end
        end
        ST_OFF: begin
          if (!ph_zero) begin
            ph_dec = 1'b1;
          end else if (!iter_last) begin
            ph_load     = 1'b1;
            ph_load_val = on_sh_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  clk_train_phase_cnt #(
    .LEN_W (LEN_W)
  ) u_phase_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (ph_load),
    .i_load_val (ph_load_val),
    .i_dec      (ph_dec),
    .o_zero     (ph_zero)
  );

  // Outputs are registered from the current state, so they trail it by one edge.
  // start_q keeps sampling through reset so a level held across reset is not a rise.
  always_ff @(posedge i_clk) begin
    start_q <= bus.i_start;
    if (i_rst) begin
      state_q    <= ST_IDLE;
      clk_en_q   <= '1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      iter_cnt_q <= '0;
      on_sh_q    <= '0;
      off_sh_q   <= '0;
      iter_sh_q  <= '0;
      mask_sh_q  <= '0;
    end else if (bus.i_abort) begin
      state_q  <= ST_IDLE;
      clk_en_q <= idle_en;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      busy_q   <= is_busy_state(state_q);
      done_q   <= 1'b0;
      clk_en_q <= idle_en;
      case (state_q)
        ST_IDLE: begin
          if (rise) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          on_sh_q    <= on_len_eff;
          off_sh_q   <= bus.i_off_len;
          iter_sh_q  <= bus.i_iter_num;
          mask_sh_q  <= bus.i_ch_mask;
          iter_cnt_q <= '0;
          state_q    <= (bus.i_iter_num == '0) ? ST_DONE : ST_ON;
        end
        ST_ON: begin
          clk_en_q <= idle_en | mask_sh_q;
          if (ph_zero) begin
            if (off_sh_q != '0) begin
              state_q <= ST_OFF;
            end else begin
              iter_cnt_q <= iter_sat;
              state_q    <= iter_last ? ST_DONE : ST_ON;
            end
          end
        end
        ST_OFF: begin
          clk_en_q <= idle_en & ~mask_sh_q;
          if (ph_zero) begin
            iter_cnt_q <= iter_sat;
            state_q    <= iter_last ? ST_DONE : ST_ON;
          end
        end
        ST_DONE: begin
          // Leave only once o_done has been visible, so a dropped request still pulses it.
          if (done_q && !bus.i_start) begin
            state_q <= ST_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_clk_en   = clk_en_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done     = done_q;
  assign bus.o_iter_cnt = iter_cnt_q;
  assign bus.o_state    = state_q;

endmodule

// File: tb/tb_clk_train_pattern_gen.sv
// Bench for clk_train_pattern_gen: directed and randomized runs scored against
// a cycle-offset model derived from the run parameters.
module tb_clk_train_pattern_gen;
  import ucie_mb_clk_pkg::*;

  localparam int NUM_CH = 3;
  localparam int LEN_W  = 5;
  localparam int ITER_W = 7;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [NUM_CH-1:0] exp_q[$];

  clk_train_pattern_gen_if #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .ITER_W(ITER_W)) bus ();

  clk_train_pattern_gen #(.NUM_CH(NUM_CH), .LEN_W(LEN_W), .ITER_W(ITER_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Offset m counts observations after the edge that first samples i_start high.
  // Pattern index j is visible at m=2+j; busy spans m=1..1+L; done starts at m=2+L.
  task automatic run_one(input int on, input int off, input int iter,
                         input logic [NUM_CH-1:0] mask, input logic park,
                         input int drop_m, input int abort_m, input bit scramble);
    int on_e, p, l, done_end, last_m, ph, it_exp;
    bit aborted;
    logic [NUM_CH-1:0] idle, en_exp;
    on_e = (on == 0) ? 1 : on;
    p    = on_e + off;
    l    = iter * p;
    idle = {NUM_CH{~park}};
    done_end = (drop_m + 1 > 3 + l) ? drop_m + 1 : 3 + l;
    last_m   = done_end + 1;
    if (abort_m >= 0 && abort_m + 2 > last_m) last_m = abort_m + 2;

    exp_q.delete();
    for (int m = 0; m <= last_m; m++) begin
      if (m >= 2 && m < 2 + l && !(abort_m >= 0 && m >= abort_m)) begin
        ph = (m - 2) % p;
        en_exp = (ph < on_e) ? (idle | mask) : (idle & ~mask);
      end else begin
        en_exp = idle;
      end
      exp_q.push_back(en_exp);
    end

    bus.i_on_len   = LEN_W'(on);
    bus.i_off_len  = LEN_W'(off);
    bus.i_iter_num = ITER_W'(iter);
    bus.i_ch_mask  = mask;
    bus.i_park     = park;
    bus.i_abort    = 1'b0;
    bus.i_start    = 1'b1;

    for (int m = 0; m <= last_m; m++) begin
      @(negedge clk);
      aborted = (abort_m >= 0) && (m >= abort_m);
      check("clk_en", 32'(bus.o_clk_en), 32'(exp_q.pop_front()));
      check("busy", 32'(bus.o_busy), 32'(!aborted && m >= 1 && m <= 1 + l));
      check("done", 32'(bus.o_done), 32'(!aborted && m >= 2 + l && m < done_end));
      if (m >= 1) begin
        it_exp = aborted ? (abort_m - 2) / p : (m - 1) / p;
        if (it_exp > iter) it_exp = iter;
        check("iter_cnt", 32'(bus.o_iter_cnt), 32'(it_exp));
      end
      if (scramble && m >= 1) begin
        bus.i_on_len   = LEN_W'($urandom_range(0, 31));
        bus.i_off_len  = LEN_W'($urandom_range(0, 31));
        bus.i_iter_num = ITER_W'($urandom_range(0, 127));
        bus.i_ch_mask  = NUM_CH'($urandom_range(0, 7));
      end
      bus.i_abort = (abort_m >= 0) && (m == abort_m - 1);
      if (m == drop_m) bus.i_start = 1'b0;
    end
    bus.i_abort = 1'b0;
    bus.i_start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int on, off, iter, l, drop, abrt;
    rst            = 1'b1;
    bus.i_start    = 1'b1;
    bus.i_abort    = 1'b0;
    bus.i_on_len   = '0;
    bus.i_off_len  = '0;
    bus.i_iter_num = '0;
    bus.i_ch_mask  = '0;
    bus.i_park     = 1'b0;

    // reset with request held high: no run until the request toggles
    repeat (3) @(negedge clk);
    check("rst_clk_en", 32'(bus.o_clk_en), 32'h7);
    check("rst_busy", 32'(bus.o_busy), 0);
    check("rst_done", 32'(bus.o_done), 0);
    check("rst_iter", 32'(bus.o_iter_cnt), 0);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_busy", 32'(bus.o_busy), 0);
      check("post_rst_en", 32'(bus.o_clk_en), 32'h7);
    end
    bus.i_start = 1'b0;
    @(negedge clk);

    // legacy pattern, request held 3 cycles past done
    l = LEGACY_ITER_NUM * (LEGACY_ON_LEN + LEGACY_OFF_LEN);
    run_one(LEGACY_ON_LEN, LEGACY_OFF_LEN, LEGACY_ITER_NUM, 3'b111, 1'b0, 2 + l + 3, -1, 1'b0);
    check("legacy_iter_final", 32'(bus.o_iter_cnt), 32'(LEGACY_ITER_NUM));

    // zero lengths / zero iterations
    run_one(0, 0, 2, 3'b111, 1'b0, 5, -1, 1'b1);
    run_one(4, 3, 0, 3'b111, 1'b0, 4, -1, 1'b1);
    run_one(4, 3, 0, 3'b101, 1'b1, 1, -1, 1'b0);

    // mask/park
    run_one(3, 2, 4, 3'b010, 1'b1, 30, -1, 1'b1);

    // abort on cycle 10 of legacy run, request held; then a clean restart
    run_one(LEGACY_ON_LEN, LEGACY_OFF_LEN, LEGACY_ITER_NUM, 3'b111, 1'b0, 20, 10, 1'b0);
    run_one(2, 1, 3, 3'b111, 1'b0, 2, -1, 1'b0);

    // request held long after done, then a second run restarting the count
    run_one(2, 2, 3, 3'b011, 1'b0, 2 + 12 + 8, -1, 1'b0);
    run_one(1, 0, 5, 3'b110, 1'b0, 2 + 5, -1, 1'b1);

    // randomized runs
    for (int r = 0; r < 40; r++) begin
      on   = $urandom_range(0, 7);
      off  = $urandom_range(0, 5);
      iter = $urandom_range(0, 6);
      l    = iter * (((on == 0) ? 1 : on) + off);
      drop = $urandom_range(2, l + 6);
      abrt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, l + 4)) : -1;
      run_one(on, off, iter, NUM_CH'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              drop, abrt, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
